// File: rtl/ram_pkg.sv
// ============================================================================
// Module   : ram_pkg
// Brief    : Shared constants, lane helper and clear-FSM state type for the
//            byte-enabled simple-dual-port RAM.
// Revision : 1.0
// ============================================================================
`default_nettype none

package ram_pkg;

    localparam int BYTE_W = 8;

    function automatic int num_lanes(input int data_width);
        return data_width / BYTE_W;
    endfunction

    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        READY = 1'b1
    } clr_state_t;

endpackage

`default_nettype wire

// File: rtl/ram_clear_ctrl.sv
// ============================================================================
// Module   : ram_clear_ctrl
// Brief    : Post-reset sequencer that walks every address once, zero-filling
//            the array before the user ports are opened.
// Revision : 1.0
// ============================================================================
`default_nettype none

module ram_clear_ctrl
    import ram_pkg::*;
#(
    parameter int ADDR_WIDTH     = 9,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  busy,
    output logic                  clr_we,
    output logic [ADDR_WIDTH-1:0] clr_addr
);

    clr_state_t            r_state;
    clr_state_t            w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_clr_addr;
    logic [ADDR_WIDTH-1:0] w_clr_addr_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            if (CLEAR_ON_RESET != 0) begin
                r_state <= CLEAR;
            end else begin
                r_state <= READY;
            end
            r_clr_addr <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_clr_addr <= w_clr_addr_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_clr_addr_nxt = r_clr_addr;
        case (r_state)
            CLEAR: begin
                w_clr_addr_nxt = r_clr_addr + 1'b1;
                // Leave once the last word is being written this cycle.
                if (&r_clr_addr) begin
                    w_state_nxt = READY;
                end
            end
            default: begin
                w_state_nxt = READY;
            end
        endcase
    end

    assign busy     = (r_state == CLEAR);
    assign clr_we   = busy;
    assign clr_addr = r_clr_addr;

endmodule

`default_nettype wire

// File: rtl/ram_sdp_be.sv
// ============================================================================
// Module   : ram_sdp_be
// Brief    : Single-clock simple-dual-port RAM with byte enables, optional
//            output register, selectable read-during-write and zero clear.
// Revision : 1.0
// ============================================================================
`default_nettype none

module ram_sdp_be
    import ram_pkg::*;
#(
    parameter int ADDR_WIDTH     = 9,
    parameter int DATA_WIDTH     = 8,
    parameter int OUT_REG        = 0,
    parameter int BYPASS         = 1,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            write_en,
    input  logic [ADDR_WIDTH-1:0]           waddr,
    input  logic [DATA_WIDTH-1:0]           din,
    input  logic [DATA_WIDTH/BYTE_W-1:0]    wbe,
    input  logic                            read_en,
    input  logic [ADDR_WIDTH-1:0]           raddr,
    output logic [DATA_WIDTH-1:0]           dout,
    output logic                            dout_valid,
    output logic                            busy
);

    localparam int c_LANES = num_lanes(DATA_WIDTH);
    localparam int c_DEPTH = 2 ** ADDR_WIDTH;

    generate
        if (((DATA_WIDTH % BYTE_W) != 0) || (DATA_WIDTH < BYTE_W)) begin : g_bad_width
            $error("ram_sdp_be: DATA_WIDTH must be a non-zero multiple of 8");
        end
    endgenerate

    logic                  w_clr_we;
    logic [ADDR_WIDTH-1:0] w_clr_addr;

    ram_clear_ctrl #(
        .ADDR_WIDTH     (ADDR_WIDTH),
        .CLEAR_ON_RESET (CLEAR_ON_RESET)
    ) u_clear_ctrl (
        .clk      (clk),
        .rst      (rst),
        .busy     (busy),
        .clr_we   (w_clr_we),
        .clr_addr (w_clr_addr)
    );

    // The clear sequencer owns the write port outright while busy.
    logic                  w_we;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [DATA_WIDTH-1:0] w_din;
    logic [c_LANES-1:0]    w_be;

    assign w_we   = busy ? w_clr_we   : write_en;
    assign w_addr = busy ? w_clr_addr : waddr;
    assign w_din  = busy ? '0         : din;
    assign w_be   = busy ? '1         : wbe;

    logic [DATA_WIDTH-1:0] r_mem [0:c_DEPTH-1];

    always_ff @(posedge clk) begin
        if (w_we) begin
            for (int i = 0; i < c_LANES; i++) begin
                if (w_be[i]) begin
                    r_mem[w_addr][i*BYTE_W +: BYTE_W] <= w_din[i*BYTE_W +: BYTE_W];
                end
            end
        end
    end

    logic                  w_rd_fire;
    logic [DATA_WIDTH-1:0] w_rd_word;

    assign w_rd_fire = read_en && !busy;

    always_comb begin
        w_rd_word = r_mem[raddr];
        if (BYPASS != 0) begin
            for (int i = 0; i < c_LANES; i++) begin
                if (write_en && wbe[i] && (waddr == raddr)) begin
                    w_rd_word[i*BYTE_W +: BYTE_W] = din[i*BYTE_W +: BYTE_W];
                end
            end
        end
    end

    logic [DATA_WIDTH-1:0] r_rd_data;
    logic                  r_rd_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= w_rd_fire;
            if (w_rd_fire) begin
                r_rd_data <= w_rd_word;
            end
        end
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic [DATA_WIDTH-1:0] r_out_data;
            logic                  r_out_valid;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_out_data  <= '0;
                    r_out_valid <= 1'b0;
                end else begin
                    r_out_valid <= r_rd_valid;
                    if (r_rd_valid) begin
                        r_out_data <= r_rd_data;
                    end
                end
            end

            assign dout       = r_out_data;
            assign dout_valid = r_out_valid;
        end else begin : g_no_out_reg
            assign dout       = r_rd_data;
            assign dout_valid = r_rd_valid;
        end
    endgenerate

endmodule

`default_nettype wire

// File: tb/tb_ram_sdp_be.sv
// ============================================================================
// Module   : tb_ram_sdp_be
// Brief    : Scoreboard bench driving two RAM instances (write-first/latency 1
//            and read-first/latency 2) from one stimulus stream.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_ram_sdp_be;

    localparam int AW    = 4;
    localparam int DW    = 16;
    localparam int NL    = DW / 8;
    localparam int DEPTH = 2 ** AW;

    logic          clk      = 1'b0;
    logic          rst      = 1'b1;
    logic          write_en = 1'b0;
    logic          read_en  = 1'b0;
    logic [AW-1:0] waddr    = '0;
    logic [AW-1:0] raddr    = '0;
    logic [DW-1:0] din      = '0;
    logic [NL-1:0] wbe      = '0;

    logic [DW-1:0] dout_a, dout_b;
    logic          dv_a, dv_b, busy_a, busy_b;

    ram_sdp_be #(
        .ADDR_WIDTH (AW), .DATA_WIDTH (DW), .OUT_REG (0), .BYPASS (1), .CLEAR_ON_RESET (1)
    ) u_dut_a (
        .clk (clk), .rst (rst), .write_en (write_en), .waddr (waddr), .din (din), .wbe (wbe),
        .read_en (read_en), .raddr (raddr), .dout (dout_a), .dout_valid (dv_a), .busy (busy_a)
    );

    ram_sdp_be #(
        .ADDR_WIDTH (AW), .DATA_WIDTH (DW), .OUT_REG (1), .BYPASS (0), .CLEAR_ON_RESET (1)
    ) u_dut_b (
        .clk (clk), .rst (rst), .write_en (write_en), .waddr (waddr), .din (din), .wbe (wbe),
        .read_en (read_en), .raddr (raddr), .dout (dout_b), .dout_valid (dv_b), .busy (busy_b)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] data;
        int            due;
    } exp_t;

    exp_t          qa[$];
    exp_t          qb[$];
    logic [DW-1:0] ref_mem [DEPTH];
    int            clr_left = 0;
    bit            exp_busy = 1'b0;
    bit            mon_en   = 1'b0;
    int            cyc      = 0;
    int            n_checks = 0;
    int            n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: evaluated right after each rising edge on the inputs
    // that edge sampled; cycle index cyc names the cycle that edge opens.
    task automatic tick();
        logic [DW-1:0] old_r, old_w, new_w;
        @(posedge clk);
        cyc++;
        if (rst) begin
            clr_left = DEPTH;
            qa.delete();
            qb.delete();
            for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
            mon_en = 1'b1;
        end else if (clr_left > 0) begin
            clr_left--;
        end else begin
            old_w = ref_mem[waddr];
            new_w = old_w;
            for (int l = 0; l < NL; l++)
                if (wbe[l]) new_w[l*8 +: 8] = din[l*8 +: 8];
            if (read_en) begin
                old_r = ref_mem[raddr];
                qa.push_back('{(write_en && waddr == raddr) ? new_w : old_r, cyc});
                qb.push_back('{old_r, cyc + 1});
            end
            if (write_en) ref_mem[waddr] = new_w;
        end
        exp_busy = (clr_left > 0);
        #1;
    endtask

    task automatic drive(input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                         input logic [NL-1:0] be, input logic re, input logic [AW-1:0] ra);
        write_en = we; waddr = wa; din = wd; wbe = be; read_en = re; raddr = ra;
        tick();
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, '0, '0, '0, 1'b0, '0);
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        idle(n);
        rst = 1'b0;
    endtask

    task automatic read_all();
        for (int a = 0; a < DEPTH; a++) drive(1'b0, '0, '0, '0, 1'b1, AW'(a));
    endtask

    task automatic port_check(input int which, input logic dv, input logic [DW-1:0] d);
        exp_t e;
        if (dv !== 1'b1) return;
        if ((which == 0 && qa.size() == 0) || (which == 1 && qb.size() == 0)) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_valid_%0d: got dout %0h with nothing pending (cycle %0d)",
                     which, d, cyc);
            return;
        end
        if (which == 0) e = qa.pop_front();
        else            e = qb.pop_front();
        chk(which == 0 ? "rd_data_a" : "rd_data_b", 32'(d), 32'(e.data));
        chk(which == 0 ? "rd_cycle_a" : "rd_cycle_b", cyc, e.due);
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            chk("busy_a", 32'(busy_a), 32'(exp_busy));
            chk("busy_b", 32'(busy_b), 32'(exp_busy));
            if (exp_busy) begin
                chk("idle_out_a", {15'd0, dv_a, dout_a}, 32'd0);
                chk("idle_out_b", {15'd0, dv_b, dout_b}, 32'd0);
            end
            port_check(0, dv_a, dout_a);
            port_check(1, dv_b, dout_b);
        end
    end

    initial begin
        logic [AW-1:0] wa, ra;

        // Reset and full clear, then every word must read zero.
        do_reset(2);
        idle(DEPTH);
        read_all();

        // Byte-lane masking on one word.
        drive(1'b1, 4'd3, 16'hA5C3, 2'b11, 1'b0, '0);
        drive(1'b1, 4'd3, 16'hFF00, 2'b01, 1'b0, '0);
        drive(1'b0, '0, '0, '0, 1'b1, 4'd3);

        // Read-during-write to the same address, then a follow-up read.
        drive(1'b1, 4'd7, 16'h1234, 2'b11, 1'b0, '0);
        drive(1'b1, 4'd7, 16'hABCD, 2'b10, 1'b1, 4'd7);
        drive(1'b0, '0, '0, '0, 1'b1, 4'd7);

        // Back-to-back reads.
        drive(1'b0, '0, '0, '0, 1'b1, 4'd0);
        drive(1'b0, '0, '0, '0, 1'b1, 4'd1);
        drive(1'b0, '0, '0, '0, 1'b1, 4'd2);
        idle(3);

        // Requests issued during the clear must be ignored.
        do_reset(1);
        drive(1'b1, 4'd5, 16'hFFFF, 2'b11, 1'b1, 4'd5);
        idle(DEPTH - 1);
        drive(1'b0, '0, '0, '0, 1'b1, 4'd5);
        idle(3);

        // Reset landing in the middle of a clear restarts it.
        do_reset(1);
        idle(9);
        do_reset(1);
        idle(DEPTH);
        read_all();
        idle(3);

        // Randomized traffic with frequent same-address collisions.
        for (int n = 0; n < 400; n++) begin
            wa = AW'($urandom_range(0, DEPTH - 1));
            ra = ($urandom_range(0, 2) == 0) ? wa : AW'($urandom_range(0, DEPTH - 1));
            drive(1'($urandom_range(0, 1)), wa, DW'($urandom), NL'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)), ra);
        end
        idle(4);

        chk("pending_a", qa.size(), 0);
        chk("pending_b", qb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/ram_sdp_be.md
# ram_sdp_be

Single-clock, simple-dual-port block RAM with per-byte write enables, configurable read latency, selectable read-during-write behaviour and a built-in clear sequencer that zeroes the array after reset. It is the general-purpose on-chip buffer for the iCE40 designs: one write port and one read port on a shared clock, targeting EBR inference. It replaces hand-instantiated fixed 512x8 arrays wherever width, byte masking or known-zero contents are needed.

## Interface

Parameters:

- ADDR_WIDTH, 9, address bits; depth is 2**ADDR_WIDTH words.
- DATA_WIDTH, 8, word width; must be a multiple of 8, otherwise elaboration fails.
- OUT_REG, 0, 1 adds an output register stage, so read latency becomes 2.
- BYPASS, 1, 1 gives write-first read-during-write to the same address; 0 gives read-first (old data).
- CLEAR_ON_RESET, 1, 1 zeroes every word after reset; 0 disables the clear sequence.

Ports:

- clk, in, 1, the single clock; all logic is on its rising edge.
- rst, in, 1, synchronous, active-high reset.
- write_en, in, 1, write request.
- waddr, in, ADDR_WIDTH, write address.
- din, in, DATA_WIDTH, write data.
- wbe, in, DATA_WIDTH/8, byte-lane write enables; bit i covers din[8i+7:8i].
- read_en, in, 1, read request.
- raddr, in, ADDR_WIDTH, read address.
- dout, out, DATA_WIDTH, read data; holds its value between reads.
- dout_valid, out, 1, one-cycle pulse aligned with new dout data.
- busy, out, 1, clear sequence in progress; requests are ignored while high.

## Operation

- Clear sequencer FSM, states CLEAR and READY:
  - With rst=1: state=CLEAR if CLEAR_ON_RESET=1, else READY. clr_addr=0.
  - CLEAR: each cycle writes all-zero to mem[clr_addr] and increments clr_addr. On the cycle that writes address 2**ADDR_WIDTH-1, go to READY.
  - READY: terminal until the next rst.
  - busy = (state==CLEAR).
- Writes: when !busy and write_en, each lane i with wbe[i]=1 is updated from din; lanes with wbe[i]=0 keep their value. write_en with wbe=0 is a no-op.
- Reads: when !busy and read_en, mem[raddr] is captured. With OUT_REG=1 it passes through one more register.
- Read-during-write to the same address in the same cycle:
  - BYPASS=1: returned word has the new din bytes in enabled lanes and old bytes elsewhere.
  - BYPASS=0: returned word is the full old word.
  - Different addresses never interact.
- While busy: write_en and read_en are ignored, and dout and dout_valid stay at 0.
- Reset mid-clear or mid-read: any pending dout_valid pipeline bits are cleared and the clear restarts from address 0. Array contents are undefined until the clear completes, or indefinitely if CLEAR_ON_RESET=0 and nothing has been written.

## Timing

- Reset values: dout=0, dout_valid=0, busy=CLEAR_ON_RESET. Internal valid-pipeline bits are 0.
- busy stays high for exactly 2**ADDR_WIDTH cycles after the first cycle with rst=0. The first accepted request is in the cycle busy reads 0.
- Read latency L = 1+OUT_REG. read_en sampled at edge N gives dout and dout_valid=1 after edge N+L-1, i.e. visible in cycle N+L.
- Back-to-back reads give one result per cycle. No stalls, no backpressure.
- A write accepted at edge N is visible to a non-bypassed read sampled at edge N+1 or later.

## Structure

- Shared package ram_pkg:
  - constant BYTE_W=8.
  - function num_lanes(DATA_WIDTH).
  - enum clr_state_t {CLEAR, READY}.
- Sub-module ram_clear_ctrl: the clear FSM and ADDR_WIDTH-bit counter. Outputs busy, clr_we and clr_addr.
- Top level:
  - muxes the clear write into the write port;
  - holds the memory array as per-lane writes for byte-enable EBR inference;
  - contains the bypass merge and the latency pipeline.

## Test plan

- Reset clear, ADDR_WIDTH=4, DATA_WIDTH=16: rst for 2 cycles -> busy high exactly 16 cycles. Afterwards, reading every address returns 0x0000 with dout_valid one cycle after read_en.
- Byte enables: write 0xA5C3 to addr 3 with wbe=2'b11, then 0xFF00 with wbe=2'b01 -> read of addr 3 returns 0xA500.
- Read-during-write, mem[7]=0x1234, write 0xABCD with wbe=2'b10 to addr 7 while reading addr 7:
  - BYPASS=1 -> 0xAB34.
  - BYPASS=0 -> 0x1234; a following read returns 0xAB34.
- OUT_REG=1: reads of addr 0,1,2 on three consecutive cycles -> data appears in order 2 cycles after each request, with dout_valid high for three consecutive cycles.
- Requests while busy: write 0xFFFF to addr 5 and read addr 5 during the clear -> no dout_valid. After busy drops, a read of addr 5 returns 0x0000.
- Reset mid-clear: assert rst at clear cycle 9 -> busy stays high for 16 full cycles after rst drops, and all words read 0.
